// File: rtl/vga_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_dac_pkg
// Purpose  : Shared constants and types for the VGA DAC palette controller.
// Revision : 1.0 - initial release
// ============================================================================
package vga_dac_pkg;

    localparam int          c_DEPTH        = 256;
    localparam int          c_RGB_W        = 18;

    localparam logic [1:0]  c_PORT_MASK    = 2'd0;
    localparam logic [1:0]  c_PORT_RDIDX   = 2'd1;
    localparam logic [1:0]  c_PORT_WRIDX   = 2'd2;
    localparam logic [1:0]  c_PORT_DATA    = 2'd3;

    localparam logic [7:0]  c_STATUS_WRITE = 8'h00;
    localparam logic [7:0]  c_STATUS_READ  = 8'h03;

    typedef enum logic [1:0] {
        COMP_R = 2'd0,
        COMP_G = 2'd1,
        COMP_B = 2'd2
    } comp_t;

    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } mode_t;

    function automatic logic [5:0] comp_sel(input logic [17:0] triplet, input comp_t comp);
        case (comp)
            COMP_R:  comp_sel = triplet[17:12];
            COMP_G:  comp_sel = triplet[11:6];
            default: comp_sel = triplet[5:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_dac_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_dac_ctrl_if
// Purpose  : Host DAC port and pixel lookup bundle for vga_dac_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_dac_ctrl_if;

    logic [1:0]  io_address;
    logic        io_write;
    logic        io_read;
    logic [7:0]  io_data_in;
    logic [7:0]  io_data_out;
    logic        io_busy;
    logic        io_overrun;
    logic        pix_valid;
    logic [7:0]  pix_index;
    logic [17:0] rgb;
    logic        rgb_valid;

    modport master (
        output io_address, io_write, io_read, io_data_in, pix_valid, pix_index,
        input  io_data_out, io_busy, io_overrun, rgb, rgb_valid
    );

    modport slave (
        input  io_address, io_write, io_read, io_data_in, pix_valid, pix_index,
        output io_data_out, io_busy, io_overrun, rgb, rgb_valid
    );

endinterface
`default_nettype wire

// File: rtl/vga_dac_ram.sv
`default_nettype none
// ============================================================================
// Module   : vga_dac_ram
// Purpose  : 256x18 single-port palette RAM, registered read, write-first.
// Revision : 1.0 - initial release
// ============================================================================
module vga_dac_ram
    import vga_dac_pkg::*;
(
    input  wire logic                clk,
    input  wire logic [7:0]          i_addr,
    input  wire logic                i_we,
    input  wire logic [c_RGB_W-1:0]  i_wdata,
    output logic      [c_RGB_W-1:0]  o_rdata
);

    logic [c_RGB_W-1:0] r_mem [0:c_DEPTH-1];
    logic [c_RGB_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_rdata       <= i_wdata;
        end else begin
            r_rdata       <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vga_dac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_dac_ctrl
// Purpose  : VGA DAC palette sequencer: host port decode, triplet staging,
//            single-port RAM arbitration and the pixel lookup pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module vga_dac_ctrl
    import vga_dac_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    vga_dac_ctrl_if.slave  bus
);

    logic [7:0]          r_mask;
    logic [7:0]          r_wr_index;
    logic [7:0]          r_rd_index;
    comp_t               r_comp;
    mode_t               r_mode;
    logic [5:0]          r_stage_r;
    logic [5:0]          r_stage_g;
    logic [c_RGB_W-1:0]  r_commit_data;
    logic [7:0]          r_commit_addr;
    logic                r_write_pending;
    logic                r_prefetch_pending;
    logic                r_prefetch_inflight;
    logic [c_RGB_W-1:0]  r_prefetch_data;
    logic                r_pix_d1;
    logic [c_RGB_W-1:0]  r_rgb;
    logic                r_rgb_valid;
    logic [7:0]          r_io_data_out;
    logic                r_io_overrun;

    logic                w_pix_issue;
    logic                w_commit_issue;
    logic                w_pf_issue;
    logic [7:0]          w_ram_addr;
    logic [c_RGB_W-1:0]  w_ram_rdata;
    logic                w_rd_outstanding;
    logic                w_data_wr;
    logic                w_data_rd;
    logic                w_wr_drop;
    logic                w_rd_drop;
    logic                w_rd_ok;
    logic [7:0]          w_rd_mux;

    // Pixels always win the RAM; commit is ordered ahead of prefetch so a
    // read-after-write of the same entry sees the new triplet.
    always_comb begin
        w_pix_issue    = bus.pix_valid;
        w_commit_issue = !bus.pix_valid && r_write_pending;
        w_pf_issue     = !bus.pix_valid && !r_write_pending && r_prefetch_pending;
        if (w_pix_issue) begin
            w_ram_addr = bus.pix_index & r_mask;
        end else if (w_commit_issue) begin
            w_ram_addr = r_commit_addr;
        end else begin
            w_ram_addr = r_rd_index;
        end
    end

    vga_dac_ram u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_commit_issue),
        .i_wdata (r_commit_data),
        .o_rdata (w_ram_rdata)
    );

    // A simultaneous write owns all state changes; the read only samples.
    always_comb begin
        w_rd_outstanding = r_prefetch_pending | r_prefetch_inflight;
        w_data_wr        = bus.io_write && (bus.io_address == c_PORT_DATA);
        w_data_rd        = bus.io_read && !bus.io_write && (bus.io_address == c_PORT_DATA);
        w_wr_drop        = w_data_wr && (r_comp == COMP_B) && r_write_pending;
        w_rd_drop        = w_data_rd && w_rd_outstanding;
        w_rd_ok          = w_data_rd && !w_rd_outstanding;
        case (bus.io_address)
            c_PORT_MASK:  w_rd_mux = r_mask;
            c_PORT_RDIDX: w_rd_mux = (r_mode == MODE_READ) ? c_STATUS_READ : c_STATUS_WRITE;
            c_PORT_WRIDX: w_rd_mux = r_wr_index;
            default:      w_rd_mux = w_rd_outstanding ? 8'h00
                                     : {2'b00, comp_sel(r_prefetch_data, r_comp)};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask              <= 8'hFF;
            r_wr_index          <= 8'h00;
            r_rd_index          <= 8'h00;
            r_comp              <= COMP_R;
            r_mode              <= MODE_WRITE;
            r_stage_r           <= 6'h00;
            r_stage_g           <= 6'h00;
            r_commit_data       <= '0;
            r_commit_addr       <= 8'h00;
            r_write_pending     <= 1'b0;
            r_prefetch_pending  <= 1'b0;
            r_prefetch_inflight <= 1'b0;
            r_prefetch_data     <= '0;
            r_pix_d1            <= 1'b0;
            r_rgb               <= '0;
            r_rgb_valid         <= 1'b0;
            r_io_data_out       <= 8'h00;
            r_io_overrun        <= 1'b0;
        end else begin
            r_pix_d1            <= w_pix_issue;
            r_rgb_valid         <= r_pix_d1;
            r_prefetch_inflight <= w_pf_issue;
            r_io_overrun        <= w_wr_drop | w_rd_drop;

            if (r_pix_d1) begin
                r_rgb <= w_ram_rdata;
            end
            if (r_prefetch_inflight) begin
                r_prefetch_data <= w_ram_rdata;
            end
            if (w_commit_issue) begin
                r_write_pending <= 1'b0;
            end
            if (w_pf_issue) begin
                r_prefetch_pending <= 1'b0;
            end

            if (bus.io_read) begin
                r_io_data_out <= w_rd_mux;
            end

            if (w_rd_ok) begin
                case (r_comp)
                    COMP_R:  r_comp <= COMP_G;
                    COMP_G:  r_comp <= COMP_B;
                    default: begin
                        r_comp             <= COMP_R;
                        r_rd_index         <= r_rd_index + 8'd1;
                        r_prefetch_pending <= 1'b1;
                    end
                endcase
            end

            if (bus.io_write) begin
                case (bus.io_address)
                    c_PORT_MASK: r_mask <= bus.io_data_in;
                    c_PORT_RDIDX: begin
                        r_rd_index         <= bus.io_data_in;
                        r_comp             <= COMP_R;
                        r_mode             <= MODE_READ;
                        r_prefetch_pending <= 1'b1;
                    end
                    c_PORT_WRIDX: begin
                        r_wr_index <= bus.io_data_in;
                        r_comp     <= COMP_R;
                        r_mode     <= MODE_WRITE;
                    end
                    default: begin
                        case (r_comp)
                            COMP_R: begin
                                r_stage_r <= bus.io_data_in[5:0];
                                r_comp    <= COMP_G;
                            end
                            COMP_G: begin
                                r_stage_g <= bus.io_data_in[5:0];
                                r_comp    <= COMP_B;
                            end
                            default: begin
                                if (!r_write_pending) begin
                                    r_commit_data   <= {r_stage_r, r_stage_g, bus.io_data_in[5:0]};
                                    r_commit_addr   <= r_wr_index;
                                    r_write_pending <= 1'b1;
                                    r_wr_index      <= r_wr_index + 8'd1;
                                    r_comp          <= COMP_R;
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign bus.rgb         = r_rgb;
    assign bus.rgb_valid   = r_rgb_valid;
    assign bus.io_data_out = r_io_data_out;
    assign bus.io_overrun  = r_io_overrun;
    assign bus.io_busy     = r_write_pending | r_prefetch_pending | r_prefetch_inflight;

endmodule
`default_nettype wire

// File: doc/vga_dac_ctrl.md
# vga_dac_ctrl

Sequences the 256×18 VGA DAC palette that produces the 18-bit analog-equivalent RGB word for the IRGB down-converter. It decodes the four host DAC ports (mask, read index/status, write index, data), assembles and splits R/G/B triplets, and shares one single-port palette RAM between the pixel pipeline and host accesses. Pixel lookups always take priority; host traffic uses idle cycles.

## Interface
- No parameters; geometry is fixed at 256 entries × 18 bits (6/6/6).
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- io_address  in  2  0=mask (3C6), 1=read index/status (3C7), 2=write index (3C8), 3=data (3C9)
- io_write  in  1  one-cycle host write strobe
- io_read  in  1  one-cycle host read strobe
- io_data_in  in  8  host write data
- io_data_out  out  8  host read data, valid the cycle after io_read
- io_busy  out  1  pending palette commit or read prefetch outstanding
- io_overrun  out  1  one-cycle pulse when a data-port access is dropped
- pix_valid  in  1  pixel lookup request this cycle
- pix_index  in  8  pixel palette index
- rgb  out  18  {R[5:0],G[5:0],B[5:0]} to the IRGB converter
- rgb_valid  out  1  rgb carries the lookup issued two cycles earlier

## Operation
- Mask register: reset 8'hFF; RAM address for pixels = pix_index & mask; reads return mask.
- Write index (port 2): sets wr_index, clears component counter to R, sets mode=write. Read returns wr_index.
- Read index (port 1 write): sets rd_index, clears counter, sets mode=read, posts prefetch of entry rd_index. Port 1 read returns status: 8'h03 in read mode, 8'h00 in write mode.
- Data write (port 3): stores io_data_in[5:0] into R, G, B staging in turn. On B: triplet moves to commit register, write_pending=1, wr_index+1 (8-bit wrap 255→0), counter→R.
- Data read (port 3): returns {2'b00, component} of prefetched triplet by counter. After B: rd_index+1 (wrap), counter→R, new prefetch posted.
- Arbitration per cycle: pix_valid → pixel read; else write_pending → commit to RAM at its latched address; else prefetch pending → RAM read at rd_index. Commit precedes prefetch, so read-after-write of the same entry returns new data.
- io_busy = write_pending | prefetch_pending | prefetch in flight.
- Dropped accesses: a data write that would complete a triplet while write_pending=1, or a data read while prefetch is outstanding, is ignored (no counter/index change) and pulses io_overrun.
- Host reads from ports 0–2 and io_data_out never wait for RAM.
- Simultaneous io_read and io_write: write takes effect, read returns pre-write value.

## Timing
- Pixel: pix_valid at t → RAM address at t → RAM q at t+1 → rgb/rgb_valid registered at t+2. Fully pipelined, one lookup per cycle, latency 2.
- rgb holds last pixel value when rgb_valid=0; host cycles never disturb rgb.
- Commit: earliest cycle after B write with pix_valid=0; write_pending clears same edge.
- Prefetch: RAM read on first idle cycle; triplet captured next cycle; busy clears then.
- Continuous pix_valid starves host indefinitely; io_busy stays high. This is intended, because the blanking interval guarantees idle cycles.
- Reset (async, any time): mask=FF, wr_index=rd_index=0, counter=R, mode=write, write_pending=prefetch_pending=0, rgb=0, rgb_valid=0, io_data_out=0, io_busy=0, io_overrun=0; in-flight commit is lost; RAM contents not reset.

## Structure
- Package vga_dac_pkg: port-address constants, component-counter enum (R/G/B), status encodings 8'h00/8'h03.
- Sub-module vga_dac_ram: 256×18 single-port synchronous RAM, registered read, write-first. Instantiated once.
- Controller: counters, staging/commit registers, arbiter, pixel output pipeline.

## Test plan
- Reset, write idx 5, data 3F,00,15 with pix_valid=0; pixel index 5 → rgb=18'h3F015 two cycles later, rgb_valid=1.
- Write idx FF, two triplets (FF then 00, wrap) → both entries correct; wr_index reads 01.
- Hold pix_valid=1 during a triplet write → io_busy high, no commit; drop pix_valid → commit the next cycle, busy clears.
- Read idx 5 → status 03; three data reads return 3F,00,15; fourth read returns entry 6 R.
- Mask=0F, pix_index=F5 → lookup of entry 05; second triplet while pending → io_overrun pulse, entry unchanged.
- Assert reset mid-prefetch → all outputs at reset values; next read-index sequence works normally.
